sawtooth_phase_counter: RTL and testbench
=========================================

Name: sawtooth_phase_counter

Overview:
- Upstream stage of the sawtooth generator.
- Produces the signed fractional ramp value (Q0.N_FRAC, range -1.0 .. +1.0-LSB) together with a one-cycle "new value" strobe.
- The generator scales these values by its amplitude.
- Ramp rate is set by a programmable step and a sample-rate prescaler; supports continuous and one-shot (single ramp) operation.

Parameters:
- N_FRAC, 7: fractional bits; counter value is N_FRAC+1 bits signed.
- DIV_WIDTH, 8: width of the prescaler divider input and internal prescaler counter.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  start or restart the ramp (level sampled each cycle).
- stop_i  input  1  stop the ramp and return to IDLE.
- oneshot_i  input  1  mode, sampled when start is accepted: 1 = single ramp, 0 = continuous.
- step_i  input  N_FRAC  unsigned increment per sample (0 .. 2^N_FRAC-1).
- divider_i  input  DIV_WIDTH  sample period minus one, in clk_i cycles.
- counter_value_o  output  N_FRAC+1  signed ramp value; feeds the generator's counter_value_i.
- counter_value_strobe_o  output  1  one-cycle pulse, coincident with each new counter_value_o.
- wrap_o  output  1  one-cycle pulse, coincident with the strobe carrying a wrapped value.
- done_o  output  1  one-cycle pulse when a one-shot ramp ends.
- busy_o  output  1  high while in RUN.

Behaviour:
- Reset (rst_i=1 at posedge): state IDLE; prescaler = 0; counter_value_o = 0; strobe, wrap_o, done_o and busy_o = 0; latched mode = continuous. Reset overrides all inputs, including mid-ramp.
- All outputs are registered.
- States: IDLE, RUN.
- IDLE:
  - start_i=1 and stop_i=0: next cycle counter_value_o = -2^N_FRAC (0x80 for N_FRAC=7), strobe = 1, prescaler = 0, latch oneshot_i, go RUN.
  - Otherwise hold counter_value_o; no pulses.
- RUN, priority order (highest first):
  1. stop_i: go IDLE next cycle; value held; no strobe, wrap or done.
  2. start_i: restart exactly as from IDLE (reload 0x80, strobe, clear prescaler, re-latch mode).
  3. prescaler >= divider_i: the sample advances and the prescaler clears to 0.
  4. Otherwise the prescaler increments by 1.
- The ">=" comparison makes a mid-run reduction of divider_i take effect immediately, with no long wait-out.
- divider_i = 0 gives one strobe per clock.
- Sample period = divider_i+1 cycles; the first advance comes divider_i+1 cycles after the start strobe.
- Advance arithmetic:
  - Sum = sign-extended value + zero-extended step, computed in N_FRAC+2 bits.
  - Wrap condition: sum > 2^N_FRAC-1.
  - New value = low N_FRAC+1 bits of the sum, i.e. modulo-2^(N_FRAC+1) two's-complement wrap.
- Continuous mode: every advance drives the new value and strobe=1. On wrap, wrap_o=1 in the same cycle as the strobe.
- One-shot mode:
  - A non-wrapping advance behaves as in continuous mode.
  - A wrapping advance emits no strobe; counter_value_o holds the last value; done_o=1 for one cycle; go IDLE.
- step_i = 0: strobes continue with an unchanged value; never wraps; a one-shot ramp never completes.
- step_i is sampled live at each advance; a change applies from the next advance.
- Start and stop asserted together: stop wins in both states.
- busy_o = 1 in RUN, including the restart cycle; it is 0 in the cycle after stop or done.
- Strobe spacing is always >= 1 cycle, so the downstream generator sees one pulse per sample.

Test Plan:
- Reset mid-ramp: run with divider=0 and step=1, assert rst_i for 1 cycle -> next cycle counter_value_o=0x00, all pulses 0, busy_o=0; no strobes until start_i.
- Continuous ramp: divider=3, step=0x20, oneshot=0, pulse start_i -> strobes exactly 4 cycles apart carrying 0x80,0xA0,0xC0,0xE0,0x00,0x20,0x40,0x60,0x80. wrap_o=1 only with the second 0x80; the pattern repeats.
- Uneven wrap: divider=0, step=0x30 -> every-cycle strobes carrying 0x80,0xB0,0xE0,0x10,0x40,0x70,0xA0. wrap_o is set on 0xA0.
- One-shot: divider=1, step=0x40, oneshot=1 -> strobes carry 0x80,0xC0,0x00,0x40. Two cycles after the 0x40 strobe: done_o=1, no strobe, value holds 0x40; busy_o=0 on the following cycle.
- Stop/start priority: in RUN, assert start_i and stop_i together -> IDLE, value held, no strobe. Then start_i alone mid-period -> next cycle value 0x80 with strobe, prescaler restarted.
- Divider change: divider=10 with prescaler at 6, change divider to 2 -> advance and strobe on the next cycle; thereafter strobes every 3 cycles.

Source files
------------

// File: rtl/sawtooth_phase_counter.sv
// Phase counter feeding the sawtooth generator: signed Q0.N_FRAC ramp
// with a programmable step, a sample prescaler and one-shot/continuous modes.
module sawtooth_phase_counter #(
    parameter int N_FRAC    = 7,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 oneshot_i,
    input  logic [N_FRAC-1:0]    step_i,
    input  logic [DIV_WIDTH-1:0] divider_i,
    output logic [N_FRAC:0]      counter_value_o,
    output logic                 counter_value_strobe_o,
    output logic                 wrap_o,
    output logic                 done_o,
    output logic                 busy_o
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam logic [N_FRAC:0] RAMP_START = {1'b1, {N_FRAC{1'b0}}};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DIV_WIDTH-1:0] r_presc;
    logic [DIV_WIDTH-1:0] w_presc_nxt;
    logic [N_FRAC:0]      r_value;
    logic [N_FRAC:0]      w_value_nxt;
    logic                 r_oneshot;
    logic                 w_oneshot_nxt;
    logic                 r_strobe;
    logic                 w_strobe_nxt;
    logic                 r_wrap;
    logic                 w_wrap_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_busy;
    logic [N_FRAC+1:0]    w_sum;
    logic                 w_wrap;

    // One guard bit above the sign: the sum can only overflow upward.
    assign w_sum  = {r_value[N_FRAC], r_value} + {2'b00, step_i};
    assign w_wrap = (w_sum[N_FRAC+1:N_FRAC] == 2'b01);

    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_value_nxt   = r_value;
        w_oneshot_nxt = r_oneshot;
        w_strobe_nxt  = 1'b0;
        w_wrap_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    w_state_nxt   = ST_RUN;
                    w_presc_nxt   = '0;
                    w_value_nxt   = RAMP_START;
                    w_oneshot_nxt = oneshot_i;
                    w_strobe_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (start_i) begin
                    w_presc_nxt   = '0;
                    w_value_nxt   = RAMP_START;
                    w_oneshot_nxt = oneshot_i;
                    w_strobe_nxt  = 1'b1;
                end else if (r_presc >= divider_i) begin
                    w_presc_nxt = '0;
                    if (r_oneshot && w_wrap) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_value_nxt  = w_sum[N_FRAC:0];
                        w_strobe_nxt = 1'b1;
                        w_wrap_nxt   = w_wrap;
                    end
                end else begin
                    w_presc_nxt = r_presc + DIV_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_value   <= '0;
            r_oneshot <= 1'b0;
            r_strobe  <= 1'b0;
            r_wrap    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_value   <= w_value_nxt;
            r_oneshot <= w_oneshot_nxt;
            r_strobe  <= w_strobe_nxt;
            r_wrap    <= w_wrap_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= (w_state_nxt == ST_RUN);
        end
    end

    assign counter_value_o        = r_value;
    assign counter_value_strobe_o = r_strobe;
    assign wrap_o                 = r_wrap;
    assign done_o                 = r_done;
    assign busy_o                 = r_busy;

endmodule

// File: tb/tb_sawtooth_phase_counter.sv
// Bench for sawtooth_phase_counter: directed ramps with literal expectations
// plus randomized traffic checked every cycle against an arithmetic model.
module tb_sawtooth_phase_counter;

    localparam int NF = 7;
    localparam int DW = 8;
    localparam int VMAX = (1 << NF) - 1;
    localparam int VMOD = 1 << (NF + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          oneshot = 1'b0;
    logic [NF-1:0] step = '0;
    logic [DW-1:0] div = '0;
    logic [NF:0]   val;
    logic          stb;
    logic          wrp;
    logic          dn;
    logic          bsy;

    sawtooth_phase_counter #(.N_FRAC(NF), .DIV_WIDTH(DW)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .start_i                (start),
        .stop_i                 (stop),
        .oneshot_i              (oneshot),
        .step_i                 (step),
        .divider_i              (div),
        .counter_value_o        (val),
        .counter_value_strobe_o (stb),
        .wrap_o                 (wrp),
        .done_o                 (dn),
        .busy_o                 (bsy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int q_val[$];
    int q_cyc[$];
    int q_wrap[$];
    int done_cnt = 0;
    int d_cyc = 0;
    int d_val = 0;

    // Model: ramp value as a plain integer in -2^NF .. 2^NF-1
    bit m_valid = 0;
    bit m_busy = 0;
    bit m_os = 0;
    bit m_stb = 0;
    bit m_wrp = 0;
    bit m_dn = 0;
    int m_val = 0;
    int m_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        q_val.delete();
        q_cyc.delete();
        q_wrap.delete();
        done_cnt = 0;
    endtask

    task automatic seq_chk(input string nm, input int ex[$], input int gap,
                           input int wrap_idx);
        chk({nm, "_count"}, q_val.size() >= ex.size() ? 1 : 0, 1);
        for (int i = 0; i < ex.size(); i++) begin
            if (i < q_val.size()) begin
                chk($sformatf("%s_val%0d", nm, i), q_val[i], ex[i]);
                chk($sformatf("%s_wrap%0d", nm, i), q_wrap[i],
                    (i == wrap_idx) ? 1 : 0);
                if (gap > 0 && i > 0)
                    chk($sformatf("%s_gap%0d", nm, i), q_cyc[i] - q_cyc[i-1], gap);
            end
        end
    endtask

    initial begin
        forever begin
            bit s_rst, s_start, s_stop, s_os;
            int s_step, s_div, nv;
            @(posedge clk);
            s_rst   = rst;
            s_start = start;
            s_stop  = stop;
            s_os    = oneshot;
            s_step  = int'(step);
            s_div   = int'(div);
            m_stb = 0;
            m_wrp = 0;
            m_dn  = 0;
            if (s_rst) begin
                m_valid = 1;
                m_busy  = 0;
                m_val   = 0;
                m_os    = 0;
                m_cnt   = 0;
            end else if (s_stop) begin
                m_busy = 0;
            end else if (s_start) begin
                m_busy = 1;
                m_val  = -(VMAX + 1);
                m_stb  = 1;
                m_cnt  = 0;
                m_os   = s_os;
            end else if (m_busy) begin
                if (m_cnt >= s_div) begin
                    m_cnt = 0;
                    nv = m_val + s_step;
                    if (nv > VMAX && m_os) begin
                        m_dn   = 1;
                        m_busy = 0;
                    end else begin
                        m_wrp = (nv > VMAX);
                        if (nv > VMAX) nv = nv - VMOD;
                        m_val = nv;
                        m_stb = 1;
                    end
                end else begin
                    m_cnt++;
                end
            end
            #1;
            cyc++;
            if (m_valid) begin
                chk("value", int'(val), m_val & (VMOD - 1));
                chk("strobe", int'(stb), int'(m_stb));
                chk("wrap", int'(wrp), int'(m_wrp));
                chk("done", int'(dn), int'(m_dn));
                chk("busy", int'(bsy), int'(m_busy));
                if (stb) begin
                    q_val.push_back(int'(val));
                    q_cyc.push_back(cyc);
                    q_wrap.push_back(int'(wrp));
                end
                if (dn) begin
                    done_cnt++;
                    d_cyc = cyc;
                    d_val = int'(val);
                end
            end
        end
    end

    initial begin
        int e[$];
        tick(2);
        chk("rst_value", int'(val), 0);
        chk("rst_busy", int'(bsy), 0);
        chk("rst_strobe", int'(stb), 0);
        rst = 1'b0;
        tick(1);

        // Continuous ramp, period 4
        div = 8'd3; step = 7'h20; oneshot = 1'b0;
        clr(); start = 1'b1; tick(1); start = 1'b0; tick(33);
        e = '{128, 160, 192, 224, 0, 32, 64, 96, 128};
        seq_chk("cont", e, 4, 8);
        stop = 1'b1; tick(1); stop = 1'b0; tick(1);

        // Uneven wrap, one strobe per clock
        div = 8'd0; step = 7'h30;
        clr(); start = 1'b1; tick(1); start = 1'b0; tick(6);
        e = '{128, 176, 224, 16, 64, 112, 160};
        seq_chk("uneven", e, 1, 6);
        stop = 1'b1; tick(1); stop = 1'b0; tick(1);

        // One-shot
        div = 8'd1; step = 7'h40; oneshot = 1'b1;
        clr(); start = 1'b1; tick(1); start = 1'b0; oneshot = 1'b0; tick(10);
        e = '{128, 192, 0, 64};
        seq_chk("oneshot", e, 2, -1);
        chk("os_strobes", q_val.size(), 4);
        chk("os_done_cnt", done_cnt, 1);
        chk("os_done_val", d_val, 64);
        if (q_cyc.size() >= 4) chk("os_done_lat", d_cyc - q_cyc[3], 2);
        chk("os_busy_after", int'(bsy), 0);
        tick(1);

        // Stop and start together, then restarts
        div = 8'd5; step = 7'h10;
        clr(); start = 1'b1; tick(1); start = 1'b0; tick(7);
        start = 1'b1; stop = 1'b1; tick(1);
        chk("ss_strobe", int'(stb), 0);
        chk("ss_busy", int'(bsy), 0);
        chk("ss_value", int'(val), 144);
        start = 1'b0; stop = 1'b0; tick(2);
        clr(); start = 1'b1; tick(1); start = 1'b0;
        chk("st_strobe", int'(stb), 1);
        chk("st_value", int'(val), 128);
        chk("st_busy", int'(bsy), 1);
        tick(3); start = 1'b1; tick(1); start = 1'b0;
        chk("rs_strobe", int'(stb), 1);
        chk("rs_value", int'(val), 128);
        tick(7);
        chk("rs_count", q_val.size(), 3);
        if (q_val.size() >= 3) begin
            chk("rs_gap1", q_cyc[1] - q_cyc[0], 4);
            chk("rs_gap2", q_cyc[2] - q_cyc[1], 6);
            chk("rs_val2", q_val[2], 144);
        end
        stop = 1'b1; tick(1); stop = 1'b0; tick(1);

        // Divider reduced mid-period
        div = 8'd10; step = 7'h10;
        clr(); start = 1'b1; tick(1); start = 1'b0; tick(6);
        div = 8'd2; tick(8);
        e = '{128, 144, 160, 176};
        seq_chk("divchg", e, 0, -1);
        if (q_cyc.size() >= 4) begin
            chk("divchg_gap1", q_cyc[1] - q_cyc[0], 7);
            chk("divchg_gap2", q_cyc[2] - q_cyc[1], 3);
            chk("divchg_gap3", q_cyc[3] - q_cyc[2], 3);
        end
        stop = 1'b1; tick(1); stop = 1'b0; tick(1);

        // Reset mid-ramp
        div = 8'd0; step = 7'h01;
        start = 1'b1; tick(1); start = 1'b0; tick(5);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("mr_value", int'(val), 0);
        chk("mr_strobe", int'(stb), 0);
        chk("mr_wrap", int'(wrp), 0);
        chk("mr_done", int'(dn), 0);
        chk("mr_busy", int'(bsy), 0);
        clr(); tick(5);
        chk("mr_quiet", q_val.size(), 0);

        // Randomized traffic
        repeat (3000) begin
            rst     = ($urandom % 300) == 0;
            start   = ($urandom % 12) == 0;
            stop    = ($urandom % 25) == 0;
            oneshot = $urandom % 2;
            if ($urandom % 8 == 0) step = NF'($urandom);
            if ($urandom % 10 == 0)
                div = ($urandom % 4 == 0) ? DW'($urandom % 12) : DW'($urandom % 3);
            tick(1);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
